dual_rail_receiver: RTL

DUAL_RAIL_RECEIVER -- requirements
Module: dual_rail_receiver

---
 rtl/dual_rail_pkg.sv | 16 +
 rtl/rail_sync.sv | 33 +++
 rtl/dual_rail_receiver.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/dual_rail_pkg.sv
// Shared definitions for the dual-rail receiver.
// Contents: FSM state enum and the default values of the receiver parameters.
package dual_rail_pkg;

  localparam int unsigned DefSyncStages = 2;
  localparam int unsigned DefFaultLimit = 4;
  localparam int unsigned DefCntW       = 8;

  typedef enum logic [1:0] {
    StInit,
    StTrack,
    StSuspect,
    StFault
  } state_e;

endpackage

// File: rtl/rail_sync.sv
// Single-rail synchronizer chain.
// Ports:
//   clk_i  - sampling clock
//   rst_ni - synchronous active-low reset, loads every stage with ResetVal
//   d_i    - asynchronous input rail
//   q_o    - synchronized rail (last stage)
module rail_sync #(
  parameter int unsigned Stages   = 2,
  parameter logic        ResetVal = 1'b0
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  logic [Stages-1:0] sync_q, sync_d;

  always_comb begin
    sync_d = {sync_q[Stages-2:0], d_i};
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      sync_q <= {Stages{ResetVal}};
    end else begin
      sync_q <= sync_d;
    end
  end

  assign q_o = sync_q[Stages-1];

endmodule

// File: rtl/dual_rail_receiver.sv
// Dual-rail receiver: synchronizes a true/complement rail pair, tracks the last valid
// data bit and declares a sticky fault after FAULT_LIMIT consecutive invalid samples.
// Ports:
//   CLK       - clock, all state changes on rising edge
//   RST_n     - synchronous active-low reset
//   RAIL_P    - true rail (asynchronous)
//   RAIL_N    - complement rail (asynchronous)
//   CLR_FAULT - fault clear request, honoured only in FAULT
//   D_OUT     - last valid data value
//   D_VALID   - current registered sample valid and not faulted
//   D_CHG     - one-cycle pulse when D_OUT changes
//   FAULT     - sticky fault flag
//   ERR_CNT   - saturating invalid-sample count (only with DUAL_RAIL_ERRCNT_EN)
// Build option: define DUAL_RAIL_ERRCNT_EN to add the ERR_CNT port and counter.
module dual_rail_receiver
  import dual_rail_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = DefSyncStages,
  parameter int unsigned FAULT_LIMIT = DefFaultLimit,
  parameter int unsigned CNT_W       = DefCntW
) (
  input  logic             CLK,
  input  logic             RST_n,
  input  logic             RAIL_P,
  input  logic             RAIL_N,
  input  logic             CLR_FAULT,
  output logic             D_OUT,
  output logic             D_VALID,
  output logic             D_CHG,
  output logic             FAULT
`ifdef DUAL_RAIL_ERRCNT_EN
  ,
  output logic [CNT_W-1:0] ERR_CNT
`endif
);

  localparam int unsigned RunW = $clog2(FAULT_LIMIT + 1);

  logic p_s, n_s, sample_valid;

  // Reset value P=0/N=1 keeps the pipeline holding a valid zero after release.
  rail_sync #(
    .Stages  (SYNC_STAGES),
    .ResetVal(1'b0)
  ) u_sync_p (
    .clk_i (CLK),
    .rst_ni(RST_n),
    .d_i   (RAIL_P),
    .q_o   (p_s)
  );

  rail_sync #(
    .Stages  (SYNC_STAGES),
    .ResetVal(1'b1)
  ) u_sync_n (
    .clk_i (CLK),
    .rst_ni(RST_n),
    .d_i   (RAIL_N),
    .q_o   (n_s)
  );

  assign sample_valid = p_s ^ n_s;

  state_e          state_q, state_d;
  logic [RunW-1:0] run_q, run_d;
  logic            d_out_q, d_out_d;
  logic            d_valid_q, d_valid_d;
  logic            d_chg_q, d_chg_d;
  logic            fault_q, fault_d;

  always_comb begin
    state_d   = state_q;
    run_d     = run_q;
    d_out_d   = d_out_q;
    d_valid_d = 1'b0;
    d_chg_d   = 1'b0;
    fault_d   = fault_q;
    if (state_q == StFault) begin
      // Sample is discarded here, including on the clearing edge.
      if (CLR_FAULT) begin
        state_d = StInit;
        run_d   = '0;
        fault_d = 1'b0;
      end
    end else if (sample_valid) begin
      state_d   = StTrack;
      run_d     = '0;
      d_out_d   = p_s;
      d_valid_d = 1'b1;
      d_chg_d   = (p_s != d_out_q);
    end else begin
      run_d = (state_q == StTrack) ? RunW'(1) : run_q + RunW'(1);
      if (run_d == RunW'(FAULT_LIMIT)) begin
        state_d = StFault;
        fault_d = 1'b1;
      end else begin
        state_d = (state_q == StInit) ? StInit : StSuspect;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST_n) begin
      state_q   <= StInit;
      run_q     <= '0;
      d_out_q   <= 1'b0;
      d_valid_q <= 1'b0;
      d_chg_q   <= 1'b0;
      fault_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      run_q     <= run_d;
      d_out_q   <= d_out_d;
      d_valid_q <= d_valid_d;
      d_chg_q   <= d_chg_d;
      fault_q   <= fault_d;
    end
  end

  assign D_OUT   = d_out_q;
  assign D_VALID = d_valid_q;
  assign D_CHG   = d_chg_q;
  assign FAULT   = fault_q;

`ifdef DUAL_RAIL_ERRCNT_EN
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d;

  always_comb begin
    err_cnt_d = err_cnt_q;
    if ((state_q != StFault) && !sample_valid && (err_cnt_q != '1)) begin
      err_cnt_d = err_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST_n) begin
      err_cnt_q <= '0;
    end else begin
      err_cnt_q <= err_cnt_d;
    end
  end

  assign ERR_CNT = err_cnt_q;
`else
  // Error counter not built.
`endif

endmodule
